// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID boot check sequencer.
package sysid_check_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID_REQ,
        RD_ID_WAIT,
        RD_TS_REQ,
        RD_TS_WAIT,
        PASS,
        FAIL
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1537775151;

endpackage

// File: rtl/sysid_check_timer.sv
// Response-wait counter; expired is high during the LIMIT-th enabled cycle.
module sysid_check_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    // Count starts at 0 on the first wait cycle, so LIMIT-1 marks the LIMIT-th cycle.
    assign expired = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/sysid_check_ctrl.sv
// Boot-time sysid ID/timestamp checker with bounded retry.
// Optional response timeout: define SYSID_CHECK_TIMEOUT_EN.
module sysid_check_ctrl
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    input  logic        start,
    output logic        check_done,
    output logic        check_pass,
    output logic [31:0] id_word,
    output logic [31:0] ts_word,
    output logic [3:0]  retry_count,
    output logic        timeout_seen
);

    if (MAX_RETRY > 15 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("sysid_check_ctrl: MAX_RETRY must be 0..15 and TIMEOUT_CYCLES nonzero");
    end

    state_t state, state_next;
    logic   cap_id, cap_ts, bump_retry, clear_run, retry_ok, wait_expired;

`ifdef SYSID_CHECK_TIMEOUT_EN
    logic in_wait;

    assign in_wait = (state == RD_ID_WAIT) || (state == RD_TS_WAIT);

    sysid_check_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (!in_wait),
        .enable  (in_wait),
        .expired (wait_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timeout_seen <= 1'b0;
        end else if (in_wait && wait_expired && !avm_readdatavalid) begin
            timeout_seen <= 1'b1;
        end
    end
`else
    assign wait_expired = 1'b0;
    assign timeout_seen = 1'b0;
`endif

    assign retry_ok = 32'(retry_count) < MAX_RETRY;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cap_id     = 1'b0;
        cap_ts     = 1'b0;
        bump_retry = 1'b0;
        clear_run  = 1'b0;
        case (state)
            IDLE: state_next = RD_ID_REQ;
            RD_ID_REQ: begin
                if (!avm_waitrequest) state_next = RD_ID_WAIT;
            end
            RD_ID_WAIT: begin
                if (avm_readdatavalid) begin
                    cap_id     = 1'b1;
                    state_next = RD_TS_REQ;
                end else if (wait_expired) begin
                    bump_retry = 1'b1;
                    state_next = retry_ok ? RD_ID_REQ : FAIL;
                end
            end
            RD_TS_REQ: begin
                if (!avm_waitrequest) state_next = RD_TS_WAIT;
            end
            RD_TS_WAIT: begin
                if (avm_readdatavalid) begin
                    cap_ts = 1'b1;
                    if (id_word == EXPECTED_ID && avm_readdata == EXPECTED_TS) begin
                        state_next = PASS;
                    end else begin
                        bump_retry = 1'b1;
                        state_next = retry_ok ? RD_ID_REQ : FAIL;
                    end
                end else if (wait_expired) begin
                    bump_retry = 1'b1;
                    state_next = retry_ok ? RD_ID_REQ : FAIL;
                end
            end
            PASS, FAIL: begin
                if (start) begin
                    clear_run  = 1'b1;
                    state_next = RD_ID_REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus and status outputs are decoded from the next state so they are registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            check_done  <= 1'b0;
            check_pass  <= 1'b0;
            id_word     <= '0;
            ts_word     <= '0;
            retry_count <= '0;
        end else begin
            avm_read    <= (state_next == RD_ID_REQ) || (state_next == RD_TS_REQ);
            avm_address <= ((state_next == RD_TS_REQ) || (state_next == RD_TS_WAIT))
                           ? SYSID_ADDR_TS : SYSID_ADDR_ID;
            check_done  <= (state_next == PASS) || (state_next == FAIL);
            check_pass  <= (state_next == PASS);
            if (cap_id) id_word <= avm_readdata;
            if (cap_ts) ts_word <= avm_readdata;
            if (clear_run) begin
                retry_count <= '0;
            end else if (bump_retry && retry_count != '1) begin
                retry_count <= retry_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/sysid_check_ctrl.md
# sysid_check_ctrl

Boot-time sequencer for the system-ID slave. After reset it reads the ID word and the timestamp word through an Avalon-MM read master and compares both against build-time expected values. It then reports pass or fail to the reset/boot logic, so the CPU is not released onto a mismatched hardware image. Failed comparisons are retried a bounded number of times, and the check can be re-run on request.

## Interface
Parameters:
- EXPECTED_ID, default 32'd0: expected word at sysid address 0.
- EXPECTED_TS, default 32'd1537775151: expected word at sysid address 1.
- MAX_RETRY, default 3: number of full re-reads after the first mismatch. Range 0..15.
- TIMEOUT_CYCLES, default 255: response-wait limit. Used only with SYSID_CHECK_TIMEOUT_EN.

Ports:
- clock, in, 1: single clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- avm_address, out, 1: sysid word select (0 = ID, 1 = timestamp).
- avm_read, out, 1: read request.
- avm_waitrequest, in, 1: slave stall.
- avm_readdata, in, 32: read data.
- avm_readdatavalid, in, 1: response strobe.
- start, in, 1: one-cycle pulse that re-runs the check. Honoured in PASS or FAIL only.
- check_done, out, 1: a result is valid.
- check_pass, out, 1: both words matched. Meaningful only while check_done is high.
- id_word, out, 32: last captured ID word.
- ts_word, out, 32: last captured timestamp word.
- retry_count, out, 4: mismatches counted in the current run.
- timeout_seen, out, 1: sticky flag, set when any response timed out.

## Operation
- FSM states: IDLE, RD_ID_REQ, RD_ID_WAIT, RD_TS_REQ, RD_TS_WAIT, PASS, FAIL.
- IDLE always advances to RD_ID_REQ on the next edge.
- In RD_*_REQ, avm_read=1 and avm_address is held stable.
  - The request is accepted on an edge where avm_waitrequest=0; the FSM then moves to the matching WAIT state.
  - avm_read is never dropped while waitrequest is high.
- In RD_*_WAIT, avm_read=0. On the edge where avm_readdatavalid=1, readdata is captured into id_word or ts_word.
  - RD_ID_WAIT advances to RD_TS_REQ.
  - RD_TS_WAIT evaluates the result:
    - both words equal to EXPECTED_ID/EXPECTED_TS: go to PASS;
    - otherwise, if retry_count < MAX_RETRY: increment retry_count and go to RD_ID_REQ;
    - otherwise: increment retry_count and go to FAIL.
- avm_readdatavalid is ignored outside the WAIT states.
- check_done=1 in PASS and FAIL. check_pass=1 in PASS only.
- start in PASS or FAIL:
  - clears check_done, check_pass and retry_count;
  - goes to RD_ID_REQ;
  - leaves id_word, ts_word and timeout_seen unchanged.
- start in any other state is ignored.
- MAX_RETRY=0: a single mismatch goes straight to FAIL with retry_count=1.

## Timing
- Reset values:
  - avm_read=0, avm_address=0;
  - check_done=0, check_pass=0;
  - id_word=0, ts_word=0;
  - retry_count=0, timeout_seen=0;
  - state=IDLE.
- Best case is waitrequest=0 with readdatavalid one cycle after acceptance. check_done then rises on the 5th rising edge after reset_n deasserts.
- Each stall cycle (waitrequest=1) and each extra response cycle adds exactly one cycle.
- One retry adds 4 cycles in the best case.
- Reset asserted mid-read aborts immediately to the reset values. Any in-flight response is never consumed after reset, because the FSM is in IDLE/REQ.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SYSID_CHECK_TIMEOUT_EN defined:
  - a cycle counter runs in each WAIT state and clears on leaving it;
  - when the counter reaches TIMEOUT_CYCLES without readdatavalid, the FSM sets timeout_seen and applies the mismatch rule (retry or FAIL);
  - a response arriving after the timeout is ignored;
  - timeouts are never applied in REQ states (Avalon hold rule).
- SYSID_CHECK_TIMEOUT_EN undefined:
  - no counter is built and WAIT states wait indefinitely;
  - timeout_seen is tied to 0.

## Structure
- Package sysid_check_pkg contains:
  - the state enum;
  - SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1;
  - the default EXPECTED_* constants.
- One sub-module, sysid_check_timer, holds the WAIT-state counter with clear/enable inputs and an expired output. It is instantiated only under SYSID_CHECK_TIMEOUT_EN.

## Test plan
- Zero-stall slave returning 0 and 1537775151 -> check_pass=1 and check_done=1 on edge 5; retry_count=0.
- Slave holds waitrequest for 3 cycles on each read -> same result on edge 11; avm_read stays high and avm_address stays stable throughout each stall.
- Timestamp returns 0x12345678 for the first 2 runs, then correct -> PASS with retry_count=2 and ts_word=1537775151.
- Timestamp always wrong with MAX_RETRY=3 -> FAIL with retry_count=4; start pulse -> new run with retry_count cleared to 0.
- SYSID_CHECK_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no readdatavalid -> timeout_seen=1, then FAIL after 4 attempts; a late readdatavalid is ignored.
- reset_n pulsed low during RD_TS_WAIT -> all outputs at reset values; a fresh run passes.
